// File: rtl/pad_cond_pkg.sv
// Shared types and default constants for the pad input conditioner.
// Edge-select encoding matches the two per-channel bits of edge_sel_i.
package pad_cond_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int MAX_FILTER_DEF  = 255;

    function automatic logic sel_has_rise(input edge_sel_e sel);
        return (sel == EDGE_RISE) || (sel == EDGE_BOTH);
    endfunction

    function automatic logic sel_has_fall(input edge_sel_e sel);
        return (sel == EDGE_FALL) || (sel == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/pad_deglitch_channel.sv
// One pad channel: synchroniser chain, stability counter, committed level,
// single-cycle edge pulses and a sticky, clearable event flag.
module pad_deglitch_channel
    import pad_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   CNT_W       = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pad_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] filter_len_i,
    input  edge_sel_e        edge_sel_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             pending_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   pending_q, pending_d;

    logic                   sync_s;
    logic                   mismatch;
    logic                   commit;
    logic [CNT_W:0]         cnt_inc;
    logic [CNT_W:0]         len_eff;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
        sync_s   = sync_q[SYNC_STAGES-1];
        mismatch = en_i && (sync_s != level_q);

        // One extra bit keeps counter+1 from wrapping at the top of the range.
        cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        len_eff  = (filter_len_i == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, filter_len_i};
        commit   = mismatch && (cnt_inc >= len_eff);

        cnt_d    = '0;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (commit) begin
            level_d = sync_s;
            rise_d  = sync_s;
            fall_d  = !sync_s;
        end else if (mismatch) begin
            cnt_d   = cnt_inc[CNT_W-1:0];
        end

        // A new event outranks a coincident clear.
        pending_d = pending_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end
        if ((rise_d && sel_has_rise(edge_sel_i)) || (fall_d && sel_has_fall(edge_sel_i))) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= {SYNC_STAGES{RESET_VAL}};
            cnt_q     <= '0;
            level_q   <= RESET_VAL;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
        end
    end

    assign level_o   = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// Core-side conditioning of raw asynchronous pad levels: per-channel
// sync + deglitch + edge detect, with an OR-reduced interrupt of the event flags.
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int                N_PADS      = 8,
    parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int                MAX_FILTER  = MAX_FILTER_DEF,
    parameter logic [N_PADS-1:0] RESET_VAL   = '0,
    localparam int               CNT_W       = $clog2(MAX_FILTER + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_PADS-1:0]     pad_i,
    input  logic [N_PADS-1:0]     en_i,
    input  logic [CNT_W-1:0]      filter_len_i,
    input  logic [2*N_PADS-1:0]   edge_sel_i,
    input  logic [N_PADS-1:0]     clr_i,
    output logic [N_PADS-1:0]     level_o,
    output logic [N_PADS-1:0]     rise_o,
    output logic [N_PADS-1:0]     fall_o,
    output logic [N_PADS-1:0]     pending_o,
    output logic                  irq_o
);

    generate
        for (genvar gi = 0; gi < N_PADS; gi++) begin : g_ch
            pad_deglitch_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W),
                .RESET_VAL   (RESET_VAL[gi])
            ) u_ch (
                .clk_i        (clk_i),
                .rst_ni       (rst_ni),
                .pad_i        (pad_i[gi]),
                .en_i         (en_i[gi]),
                .filter_len_i (filter_len_i),
                .edge_sel_i   (edge_sel_e'(edge_sel_i[2*gi +: 2])),
                .clr_i        (clr_i[gi]),
                .level_o      (level_o[gi]),
                .rise_o       (rise_o[gi]),
                .fall_o       (fall_o[gi]),
                .pending_o    (pending_o[gi])
            );
        end
    endgenerate

    assign irq_o = |pending_o;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed and randomised stimulus for pad_input_conditioner, checked every
// cycle against a run-length model built from the recorded input history.
module tb_pad_input_conditioner;

    localparam int          N    = 8;
    localparam int          S    = 2;
    localparam int          HMAX = 4096;
    localparam logic [7:0]  RV   = 8'hA5;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  pad_i, en_i, clr_i, filter_len_i;
    logic [15:0] edge_sel_i;
    logic [7:0]  level_o, rise_o, fall_o, pending_o;
    logic        irq_o;

    pad_input_conditioner #(
        .N_PADS      (N),
        .SYNC_STAGES (S),
        .MAX_FILTER  (255),
        .RESET_VAL   (RV)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pad_i        (pad_i),
        .en_i         (en_i),
        .filter_len_i (filter_len_i),
        .edge_sel_i   (edge_sel_i),
        .clr_i        (clr_i),
        .level_o      (level_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .pending_o    (pending_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: the synchronised value seen at edge j is the pad sampled S edges
    // earlier; a channel commits once its run of consecutive enabled
    // mismatching edges reaches the effective filter length.
    logic [7:0] pad_h [HMAX];
    logic [7:0] en_h  [HMAX];
    logic [7:0] rv_v = RV;
    int         t;
    logic [7:0] lvl_m, rise_m, fall_m, pend_m;
    logic [7:0] nl, nr, nf, np;
    int         run, jj, leff;

    function automatic logic sync_at(input int j, input int ch);
        if (j >= S) return pad_h[j-S][ch];
        return rv_v[ch];
    endfunction

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            t      = 0;
            lvl_m  = RV;
            rise_m = '0;
            fall_m = '0;
            pend_m = '0;
        end else if (t < HMAX) begin
            pad_h[t] = pad_i;
            en_h[t]  = en_i;
            leff     = (filter_len_i == 0) ? 1 : int'(filter_len_i);
            nl = lvl_m; nr = '0; nf = '0; np = pend_m;
            for (int ch = 0; ch < N; ch++) begin
                run = 0;
                jj  = t;
                while (jj >= 0 && en_h[jj][ch] && (sync_at(jj, ch) != lvl_m[ch])) begin
                    run++;
                    jj--;
                end
                if (run >= leff) begin
                    nl[ch] = ~lvl_m[ch];
                    nr[ch] = ~lvl_m[ch];
                    nf[ch] = lvl_m[ch];
                end
                if (clr_i[ch]) np[ch] = 1'b0;
                if ((nr[ch] && edge_sel_i[2*ch]) || (nf[ch] && edge_sel_i[2*ch+1])) np[ch] = 1'b1;
            end
            lvl_m = nl; rise_m = nr; fall_m = nf; pend_m = np;
            t++;
        end
        #1;
        chk("cyc_level",   level_o,   lvl_m);
        chk("cyc_rise",    rise_o,    rise_m);
        chk("cyc_fall",    fall_o,    fall_m);
        chk("cyc_pending", pending_o, pend_m);
        chk("cyc_irq",     irq_o,     |pend_m);
    end

    task automatic measure(input int ch, input logic val, input int n,
                           output int lat, output int rc, output int fc);
        lat = 0; rc = 0; fc = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_i);
            #2;
            if (lat == 0 && level_o[ch] == val) lat = k;
            rc += int'(rise_o[ch]);
            fc += int'(fall_o[ch]);
        end
    endtask

    int lat, rc, fc;

    initial begin
        pad_i        = 8'h00;
        en_i         = 8'hFF;
        clr_i        = 8'h00;
        filter_len_i = 8'd3;
        edge_sel_i   = 16'hFE7F;   // ch3 rise-only, ch4 fall-only, others both

        // Reset holds outputs regardless of pad activity.
        repeat (4) begin
            @(negedge clk_i);
            pad_i = 8'($urandom);
        end
        chk("rst_level", level_o, 8'hA5);
        chk("rst_rise", rise_o, 8'h00);
        chk("rst_fall", fall_o, 8'h00);
        chk("rst_pending", pending_o, 8'h00);
        chk("rst_irq", irq_o, 1'b0);
        pad_i = RV;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6) @(negedge clk_i);
        chk("post_rst_hold", level_o, 8'hA5);

        // Latency: fall then rise on ch0 with L=3, both on the 5th edge.
        pad_i[0] = 1'b0;
        measure(0, 1'b0, 10, lat, rc, fc);
        chk("lat_fall_edge", lat, 5);
        chk("lat_fall_pulses", fc, 1);
        @(negedge clk_i);
        pad_i[0] = 1'b1;
        measure(0, 1'b1, 10, lat, rc, fc);
        chk("lat_rise_edge", lat, 5);
        chk("lat_rise_pulses", rc, 1);
        chk("lat_rise_nofall", fc, 0);

        // Glitch reject: 2-cycle excursion dropped, 3-cycle accepted.
        @(negedge clk_i);
        pad_i[1] = 1'b1;
        fork
            begin repeat (2) @(negedge clk_i); pad_i[1] = 1'b0; end
            measure(1, 1'b1, 12, lat, rc, fc);
        join
        chk("glitch2_level", lat, 0);
        chk("glitch2_rise", rc, 0);
        chk("glitch2_pend", pending_o[1], 1'b0);
        @(negedge clk_i);
        pad_i[1] = 1'b1;
        fork
            begin repeat (3) @(negedge clk_i); pad_i[1] = 1'b0; end
            measure(1, 1'b1, 12, lat, rc, fc);
        join
        chk("glitch3_edge", lat, 5);
        chk("glitch3_rise", rc, 1);
        chk("glitch3_fall", fc, 1);
        chk("glitch3_pend", pending_o[1], 1'b1);

        // filter_len 0 behaves as 1.
        @(negedge clk_i);
        filter_len_i = 8'd0;
        pad_i[2]     = 1'b0;
        measure(2, 1'b0, 8, lat, rc, fc);
        chk("len0_edge", lat, 3);
        chk("len0_fall", fc, 1);

        // Mid-count shrink: counter reaches 4 with L=10, then L=2 commits next edge.
        @(negedge clk_i);
        filter_len_i = 8'd10;
        pad_i[2]     = 1'b1;
        measure(2, 1'b1, 6, lat, rc, fc);
        chk("midcnt_before", lat, 0);
        @(negedge clk_i);
        filter_len_i = 8'd2;
        measure(2, 1'b1, 4, lat, rc, fc);
        chk("midcnt_commit", lat, 1);

        // Enable gating on ch2.
        @(negedge clk_i);
        filter_len_i = 8'd3;
        en_i[2]      = 1'b0;
        fork
            begin repeat (10) begin pad_i[2] = ~pad_i[2]; @(negedge clk_i); end end
            measure(2, 1'b0, 10, lat, rc, fc);
        join
        chk("gate_frozen", lat, 0);
        chk("gate_norise", rc, 0);
        chk("gate_nofall", fc, 0);
        pad_i[2] = 1'b0;
        repeat (3) @(negedge clk_i);
        en_i[2] = 1'b1;
        measure(2, 1'b0, 6, lat, rc, fc);
        chk("reen_edge", lat, 3);
        chk("reen_fall", fc, 1);

        // Pending / irq.
        @(negedge clk_i);
        clr_i = 8'hFF;
        @(negedge clk_i);
        clr_i = 8'h00;
        chk("clr_all_pend", pending_o, 8'h00);
        chk("clr_all_irq", irq_o, 1'b0);
        pad_i[4] = 1'b1;
        measure(4, 1'b1, 8, lat, rc, fc);
        chk("fallsel_rise_edge", lat, 5);
        chk("fallsel_rise_pend", pending_o[4], 1'b0);
        chk("fallsel_rise_irq", irq_o, 1'b0);
        @(negedge clk_i);
        pad_i[3] = 1'b1;
        measure(3, 1'b1, 8, lat, rc, fc);
        chk("risesel_rise_pend", pending_o[3], 1'b1);
        chk("risesel_rise_irq", irq_o, 1'b1);
        @(negedge clk_i);
        clr_i[3] = 1'b1;
        @(negedge clk_i);
        clr_i = 8'h00;
        chk("clr3_pend", pending_o, 8'h00);
        chk("clr3_irq", irq_o, 1'b0);
        pad_i[3] = 1'b0;
        measure(3, 1'b0, 8, lat, rc, fc);
        chk("risesel_fall_pend", pending_o[3], 1'b0);
        @(negedge clk_i);
        pad_i[4] = 1'b0;
        measure(4, 1'b0, 8, lat, rc, fc);
        chk("fallsel_fall_pend", pending_o[4], 1'b1);
        @(negedge clk_i);
        clr_i[4] = 1'b1;
        @(negedge clk_i);
        clr_i = 8'h00;
        pad_i[3] = 1'b1;
        repeat (4) @(negedge clk_i);
        clr_i[3] = 1'b1;               // lands on the commit edge
        @(negedge clk_i);
        clr_i = 8'h00;
        chk("coinc_level", level_o[3], 1'b1);
        chk("coinc_pend", pending_o[3], 1'b1);

        // Randomised phase, checked by the per-cycle model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_i);
            if (c % 50 == 0) begin
                filter_len_i = 8'($urandom_range(0, 4));
                edge_sel_i   = 16'($urandom);
            end
            pad_i = pad_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            en_i  = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
            clr_i = 8'($urandom) & 8'($urandom) & 8'($urandom);
        end
        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
